aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
- Parametrised successor to the AES-128 key generator. Expands AES-128, AES-192 or AES-256 cipher keys, selected per operation, into round keys 0..Nr.
- Generates the round constant internally, one schedule word per cycle.
- Delivers 128-bit round keys over a valid/ready handshake to the cipher datapath.
- Shares one external 32-bit S-box (SubWord) with the rest of the core through sub_o/sub_i.

Parameters:
- MAX_KEY_BITS, 256, largest supported key (128, 192 or 256). Modes above it are rejected with cfg_err. Sets the key_i width and the window depth Nk_max = MAX_KEY_BITS/32.
- RND_IDX_W, 4, width of the round-key index output.

Ports:
- clk, in, 1, clock.
- nrst, in, 1, reset, asynchronous, active-low.
- en, in, 1, global enable; 0 freezes all state, outputs hold.
- start, in, 1, begin expansion; sampled only in IDLE with en=1.
- key_mode, in, 2, 00=128, 01=192, 10=256, 11=reserved; latched on start.
- key_i, in, MAX_KEY_BITS, cipher key, MSB-aligned (word 0 = bits [MAX_KEY_BITS-1 -: 32]); latched on start.
- sub_o, out, 32, word sent to the external S-box.
- sub_i, in, 32, SubWord(sub_o); combinational return, same cycle.
- rk_o, out, 128, round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rk_idx, out, RND_IDX_W, round number r of rk_o.
- rk_valid, out, 1, rk_o/rk_idx valid.
- rk_ready, in, 1, consumer accepts when rk_valid & rk_ready.
- busy, out, 1, high from accepted start until the final round key is accepted.
- cfg_err, out, 1, one-cycle pulse when start carries an illegal or unsupported mode.

Behaviour:
- Reset (async, nrst=0): state IDLE; rk_o, rk_idx, sub_o, window, counters = 0; rcon = 8'h01; rk_valid, busy, cfg_err = 0.
- Modes: Nk = 4/6/8, Nr = 10/12/14; total words 4(Nr+1) = 44/52/60.
- All transitions below require en=1.
- States:
  - IDLE: start with a legal mode -> EXPAND. Latch Nk and Nr, load key words into the window, word index i=0, staging count 0, rcon=01.
  - IDLE: start with an illegal or unsupported mode -> stay IDLE, cfg_err=1 next cycle.
  - EXPAND: one word per cycle unless stalled.
    - i < Nk: w[i] = key word i.
    - Otherwise w[i] = w[i-Nk] ^ t.
    - i mod Nk = 0: t = sub_i ^ {rcon,24'h0}, with sub_o = RotWord(w[i-1]); rcon then advances (xtime: 80 -> 1b).
    - Nk = 8 and i mod Nk = 4: t = sub_i, with sub_o = w[i-1].
    - Otherwise t = w[i-1]; sub_o = 0 when unused.
    - i mod Nk is a wrap counter, not a divider.
  - Staging: each word is appended to a 4-word staging register. On the 4th word, rk_valid rises the next cycle with rk_idx = r.
  - Stall: while rk_valid & !rk_ready, no word is generated and rk_o, rk_idx and sub_o hold.
  - Acceptance with rk_valid & rk_ready: staging clears. The word generated in that same cycle enters slot 0, so there is no bubble. Sustained rate is one round key per 4 cycles.
  - EXPAND -> IDLE when round Nr is accepted; busy drops the same edge.
- Latency: round 0 rk_valid asserts on the 4th rising edge after the start edge.
- start while busy is ignored; key_mode and key_i changes mid-run are ignored.
- en=0 mid-run: full freeze including rk_valid; the handshake is not counted while en=0.
- Async reset mid-run: immediate IDLE with all outputs at reset values; no partial key is reissued.

Decomposition:
- aes_pkg gains:
  - typedefs key_max_t and key_mode_e (K128/K192/K256/KRSV);
  - constants NK_TBL and NR_TBL;
  - function xtime() for rcon advance;
  - function rot_word().
- aes_32 and aes_byte are reused.
- Sub-module aes_key_word: combinational word step (inputs w_prev, w_nk, sub_i, rcon, pos, nk; outputs sub_o and w_new). It is unit-testable against FIPS-197 tables.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, start@T -> round 0 rk_o = key at T+4. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. busy falls after round 10; 11 keys total.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (MSB-aligned), mode 01 -> 13 keys. Round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, mode 10 -> 15 keys. Round 14 = fe4890d1e6188d0b046df344706c631e; the i mod 8 = 4 SubWord path is exercised.
- Backpressure: AES-128, rk_ready toggling randomly and held 0 for 7 cycles at round 3 -> rk_o stable during the stall, no word skipped, final key identical to the first test.
- mode 11 start -> cfg_err pulse, busy stays 0. A second start during AES-256 is ignored. nrst low at round 5 -> immediate reset values; restart produces the correct round 0.
- en=0 for 5 cycles mid-AES-192 -> outputs frozen; the key sequence is unchanged except for the 5-cycle shift.

Source files
------------

// File: rtl/aes_key_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sched_pkg
//  Description : Shared types, tables and byte/word helpers for the AES
//                key schedule (AES-128/192/256).
//  Contents    : key_max_t, key_mode_e, NK_TBL, NR_TBL, xtime(), rot_word()
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_key_sched_pkg;

    // Widest cipher key any build of the schedule can carry
    typedef logic [255:0] key_max_t;

    typedef enum logic [1:0] {
        K128 = 2'b00,
        K192 = 2'b01,
        K256 = 2'b10,
        KRSV = 2'b11
    } key_mode_e;

    // Indexed by key_mode; a zero entry marks the reserved encoding
    localparam logic [3:0][3:0] NK_TBL = {4'd0, 4'd8, 4'd6, 4'd4};
    localparam logic [3:0][3:0] NR_TBL = {4'd0, 4'd14, 4'd12, 4'd10};

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Cyclic left rotation by one byte
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sched_if
//  Description : Round-key delivery bus (valid/ready) from the key schedule
//                to the cipher datapath.
//  Signals     : rk_o     - 128-bit round key {w[4r]..w[4r+3]}
//                rk_idx   - round number r
//                rk_valid - rk_o/rk_idx valid
//                rk_ready - consumer accepts on rk_valid & rk_ready
//  Modports    : master (key schedule), slave (consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_sched_if #(
    parameter int RND_IDX_W = 4
) ();
    logic [127:0]          rk_o;
    logic [RND_IDX_W-1:0]  rk_idx;
    logic                  rk_valid;
    logic                  rk_ready;

    modport master (output rk_o, output rk_idx, output rk_valid, input rk_ready);
    modport slave  (input rk_o, input rk_idx, input rk_valid, output rk_ready);
endinterface
`default_nettype wire

// File: rtl/aes_key_sched_key_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_word
//  Description : Combinational key-expansion step for one schedule word
//                (i >= Nk). Chooses the S-box operand and forms
//                w[i] = w[i-Nk] ^ t.
//  Ports       : w_prev - w[i-1]          w_nk  - w[i-Nk]
//                sub_i  - SubWord(sub_o)  rcon  - current round constant
//                pos    - i mod Nk        nk    - 4, 6 or 8
//                sub_o  - S-box operand (0 when unused)
//                w_new  - w[i]
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_word
    import aes_key_sched_pkg::*;
(
    input  wire logic [31:0] w_prev,
    input  wire logic [31:0] w_nk,
    input  wire logic [31:0] sub_i,
    input  wire logic [7:0]  rcon,
    input  wire logic [2:0]  pos,
    input  wire logic [3:0]  nk,
    output logic      [31:0] sub_o,
    output logic      [31:0] w_new
);

    logic [31:0] w_t;

    always_comb begin
        sub_o = '0;
        w_t   = w_prev;
        if (pos == 3'd0) begin
            sub_o = rot_word(w_prev);
            w_t   = sub_i ^ {rcon, 24'h000000};
        end else if ((nk == 4'd8) && (pos == 3'd4)) begin
            // AES-256 only: extra SubWord half-way through each group
            sub_o = w_prev;
            w_t   = sub_i;
        end
        w_new = w_nk ^ w_t;
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sched
//  Description : AES-128/192/256 key schedule. Produces one schedule word
//                per cycle, groups them four at a time into round keys and
//                hands them out over a valid/ready bus. SubWord is done by
//                an external shared S-box.
//  Ports       : clk, nrst (async, active-low), en (global enable)
//                start, key_mode, key_i  - operation request (IDLE only)
//                sub_o / sub_i           - external S-box word out / back
//                rk_bus (master)         - round key, index, valid/ready
//                busy                    - operation in progress
//                cfg_err                 - pulse on illegal/unsupported mode
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched
    import aes_key_sched_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int RND_IDX_W    = 4
) (
    input  wire logic                    clk,
    input  wire logic                    nrst,
    input  wire logic                    en,
    input  wire logic                    start,
    input  wire logic [1:0]              key_mode,
    input  wire logic [MAX_KEY_BITS-1:0] key_i,
    output logic      [31:0]             sub_o,
    input  wire logic [31:0]             sub_i,
    aes_key_sched_if.master              rk_bus,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int         WIN_W  = MAX_KEY_BITS;
    localparam logic [3:0] NK_MAX = 4'(MAX_KEY_BITS / 32);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_EXPAND = 1'b1;

    logic [0:0]           r_state;
    // Word 0 (LSBs) is w[i-1], word k is w[i-1-k]; w[i-Nk] sits at word Nk-1
    logic [WIN_W-1:0]     r_win;
    logic [3:0]           r_nk;
    logic [3:0]           r_nr;
    logic [2:0]           r_pos;      // i mod Nk
    logic [5:0]           r_wcnt;     // i
    logic [1:0]           r_scnt;     // words held in staging
    logic [95:0]          r_stg;
    logic [7:0]           r_rcon;
    logic [RND_IDX_W-1:0] r_round;    // next round number to publish
    logic [127:0]         r_rk;
    logic [RND_IDX_W-1:0] r_rk_idx;
    logic                 r_rk_valid;
    logic                 r_cfg_err;

    key_mode_e            w_mode;
    logic [3:0]           w_mode_nk;
    logic [3:0]           w_mode_nr;
    logic                 w_mode_ok;
    logic [WIN_W-1:0]     w_win_load;
    logic [5:0]           w_total;
    logic                 w_running;
    logic                 w_stall;
    logic                 w_gen;
    logic                 w_accept;
    logic                 w_in_key;
    logic [31:0]          w_prev;
    logic [31:0]          w_nk_word;
    logic [31:0]          w_sub_step;
    logic [31:0]          w_new_step;
    logic [31:0]          w_new;
    logic                 w_last_rk;

    assign w_mode    = key_mode_e'(key_mode);
    assign w_mode_nk = NK_TBL[key_mode];
    assign w_mode_nr = NR_TBL[key_mode];
    assign w_mode_ok = (w_mode != KRSV) && (w_mode_nk <= NK_MAX);

    // Place key word 0 at window word Nk-1 and key word Nk-1 at word 0, so
    // the first Nk cycles simply pass w[i-Nk] through as the key words.
    assign w_win_load = key_i >> {NK_MAX - w_mode_nk, 5'b00000};

    assign w_total   = {r_nr + 4'd1, 2'b00};
    assign w_running = (r_state == S_EXPAND) && (r_wcnt < w_total);
    assign w_stall   = r_rk_valid && !rk_bus.rk_ready;
    assign w_gen     = en && w_running && !w_stall;
    assign w_accept  = en && r_rk_valid && rk_bus.rk_ready;
    assign w_in_key  = r_wcnt < {2'b00, r_nk};
    assign w_last_rk = (r_rk_idx == RND_IDX_W'(r_nr));

    assign w_prev    = r_win[31:0];
    assign w_nk_word = 32'(r_win >> {r_nk - 4'd1, 5'b00000});

    aes_key_word u_key_word (
        .w_prev (w_prev),
        .w_nk   (w_nk_word),
        .sub_i  (sub_i),
        .rcon   (r_rcon),
        .pos    (r_pos),
        .nk     (r_nk),
        .sub_o  (w_sub_step),
        .w_new  (w_new_step)
    );

    assign w_new = w_in_key ? w_nk_word : w_new_step;
    // Derived only from state, so it holds through stalls and en=0
    assign sub_o = (w_running && !w_in_key) ? w_sub_step : 32'h0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_win      <= '0;
            r_nk       <= '0;
            r_nr       <= '0;
            r_pos      <= '0;
            r_wcnt     <= '0;
            r_scnt     <= '0;
            r_stg      <= '0;
            r_rcon     <= 8'h01;
            r_round    <= '0;
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else if (en) begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_mode_ok) begin
                            r_state <= S_EXPAND;
                            r_win   <= w_win_load;
                            r_nk    <= w_mode_nk;
                            r_nr    <= w_mode_nr;
                            r_pos   <= '0;
                            r_wcnt  <= '0;
                            r_scnt  <= '0;
                            r_stg   <= '0;
                            r_rcon  <= 8'h01;
                            r_round <= '0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    if (w_gen) begin
                        r_win  <= {r_win[WIN_W-33:0], w_new};
                        r_wcnt <= r_wcnt + 6'd1;
                        r_pos  <= (r_pos == 3'(r_nk - 4'd1)) ? 3'd0 : r_pos + 3'd1;
                        if (!w_in_key && (r_pos == 3'd0))
                            r_rcon <= xtime(r_rcon);
                        if (r_scnt == 2'd3) begin
                            r_rk     <= {r_stg, w_new};
                            r_rk_idx <= r_round;
                            r_round  <= r_round + 1'b1;
                            r_scnt   <= 2'd0;
                            r_stg    <= '0;
                        end else begin
                            r_stg  <= {r_stg[63:0], w_new};
                            r_scnt <= r_scnt + 2'd1;
                        end
                    end

                    if (w_gen && (r_scnt == 2'd3))
                        r_rk_valid <= 1'b1;
                    else if (w_accept)
                        r_rk_valid <= 1'b0;

                    if (w_accept && w_last_rk)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rk_bus.rk_o     = r_rk;
    assign rk_bus.rk_idx   = r_rk_idx;
    assign rk_bus.rk_valid = r_rk_valid;
    assign busy            = (r_state == S_EXPAND);
    assign cfg_err         = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_sched
//  Description : Self-checking bench for aes_key_sched. Supplies the S-box,
//                keeps a FIPS-197 style key-expansion model and compares
//                every accepted round key against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic         start;
    logic [1:0]   key_mode;
    logic [255:0] key_i;
    logic [31:0]  sub_o;
    logic [31:0]  sub_i;
    logic         busy;
    logic         cfg_err;

    aes_key_sched_if rk_if ();

    aes_key_sched dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .start    (start),
        .key_mode (key_mode),
        .key_i    (key_i),
        .sub_o    (sub_o),
        .sub_i    (sub_i),
        .rk_bus   (rk_if),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    logic [7:0]   sbox_tbl [256];
    logic [127:0] ref_rk   [15];
    logic [127:0] got_rk   [15];
    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // External S-box: combinational, same cycle
    assign sub_i = {sbox_tbl[sub_o[31:24]], sbox_tbl[sub_o[23:16]],
                    sbox_tbl[sub_o[15:8]],  sbox_tbl[sub_o[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_tbl[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    task automatic ref_expand(input logic [1:0] mode, input logic [255:0] key);
        int nk;
        int nr;
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        nk = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 6 : 8;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                    rc  = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        for (int r = 0; r <= nr; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one expansion, checking each accepted key, stall holding and en freeze
    task automatic run_keys(input logic [1:0] mode, input logic [255:0] key,
                            input int rdy_pct, input int hold_round, input int hold_len,
                            input int en_off_at, input int en_off_len, input int restart_at,
                            output int nacc, output int first_lat, output int cyc);
        int nr;
        int hold_cnt;
        logic frz;
        logic stl;
        logic ready;
        logic [127:0] s_rk;
        logic [3:0]   s_idx;
        logic         s_v;
        logic         s_busy;
        logic [31:0]  s_sub;
        nr = (mode == 2'd0) ? 10 : (mode == 2'd1) ? 12 : 14;
        ref_expand(mode, key);
        for (int k = 0; k < 15; k++) got_rk[k] = '0;
        en = 1'b1; start = 1'b1; key_mode = mode; key_i = key; rk_if.rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; nacc = 0; first_lat = -1; hold_cnt = 0;
        while (nacc < nr + 1 && cyc < 600) begin
            key_i    = {rnd128(), rnd128()};
            key_mode = 2'($urandom);
            start    = (cyc == restart_at);
            en       = !(cyc >= en_off_at && cyc < en_off_at + en_off_len);
            if (rk_if.rk_valid && rk_if.rk_idx == 4'(hold_round) && hold_cnt < hold_len) begin
                ready = 1'b0;
                hold_cnt++;
            end else begin
                ready = ($urandom_range(99) < rdy_pct);
            end
            rk_if.rk_ready = ready;
            frz = !en;
            stl = en && rk_if.rk_valid && !ready;
            s_rk = rk_if.rk_o; s_idx = rk_if.rk_idx; s_v = rk_if.rk_valid; s_busy = busy; s_sub = sub_o;
            if (en && rk_if.rk_valid && ready) begin
                n_chk++;
                if ({rk_if.rk_idx, rk_if.rk_o} !== {4'(nacc), ref_rk[nacc]})
                    $display("FAIL round_key mode=%0d: got idx=%0d rk=%h want idx=%0d rk=%h", mode, rk_if.rk_idx, rk_if.rk_o, nacc, ref_rk[nacc]);
                else
                    n_pass++;
                got_rk[nacc] = rk_if.rk_o;
                nacc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (first_lat < 0 && rk_if.rk_valid) first_lat = cyc;
            if (frz) begin
                n_chk++;
                if ({rk_if.rk_o, rk_if.rk_idx, rk_if.rk_valid, busy, sub_o} !== {s_rk, s_idx, s_v, s_busy, s_sub})
                    $display("FAIL en_freeze: got rk=%h idx=%0d v=%b busy=%b sub=%h want rk=%h idx=%0d v=%b busy=%b sub=%h", rk_if.rk_o, rk_if.rk_idx, rk_if.rk_valid, busy, sub_o, s_rk, s_idx, s_v, s_busy, s_sub);
                else
                    n_pass++;
            end
            if (stl) begin
                n_chk++;
                if ({rk_if.rk_valid, rk_if.rk_o, rk_if.rk_idx, sub_o} !== {1'b1, s_rk, s_idx, s_sub})
                    $display("FAIL stall_hold: got v=%b rk=%h idx=%0d sub=%h want v=1 rk=%h idx=%0d sub=%h", rk_if.rk_valid, rk_if.rk_o, rk_if.rk_idx, sub_o, s_rk, s_idx, s_sub);
                else
                    n_pass++;
            end
        end
        start = 1'b0; en = 1'b1; rk_if.rk_ready = 1'b1;
        if (nacc < nr + 1) begin
            n_chk++;
            $display("FAIL timeout mode=%0d: got %0d keys want %0d", mode, nacc, nr + 1);
        end
        n_chk++;
        if ({busy, rk_if.rk_valid} !== 2'b00)
            $display("FAIL end_idle mode=%0d: got busy=%b valid=%b want 0 0", mode, busy, rk_if.rk_valid);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b0; start = 1'b0; key_mode = 2'd0; key_i = '0; rk_if.rk_ready = 1'b0;
        #1;
        n_chk++;
        if ({rk_if.rk_valid, busy, cfg_err, rk_if.rk_idx, rk_if.rk_o, sub_o} !== '0)
            $display("FAIL reset_state: got v=%b busy=%b err=%b idx=%0d rk=%h sub=%h want all 0", rk_if.rk_valid, busy, cfg_err, rk_if.rk_idx, rk_if.rk_o, sub_o);
        else
            n_pass++;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic test_aes128();
        int nacc, lat, cyc;
        run_keys(2'd0, {K128, rnd128()}, 100, -1, 0, -1, 0, -1, nacc, lat, cyc);
        n_chk++;
        if (lat !== 4) $display("FAIL aes128_latency: got %0d want 4", lat); else n_pass++;
        n_chk++;
        if (cyc !== 45) $display("FAIL aes128_cycles: got %0d want 45", cyc); else n_pass++;
        n_chk++;
        if (got_rk[0] !== K128) $display("FAIL aes128_round0: got %h want %h", got_rk[0], K128); else n_pass++;
        n_chk++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL aes128_round1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]); else n_pass++;
        n_chk++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL aes128_round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); else n_pass++;
    endtask

    task automatic test_aes192();
        int nacc, lat, cyc;
        run_keys(2'd1, {K192, 64'($urandom)}, 100, -1, 0, -1, 0, -1, nacc, lat, cyc);
        n_chk++;
        if (cyc !== 53) $display("FAIL aes192_cycles: got %0d want 53", cyc); else n_pass++;
        n_chk++;
        if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) $display("FAIL aes192_round12: got %h want e98ba06f448c773c8ecc720401002202", got_rk[12]); else n_pass++;
    endtask

    task automatic test_aes256_restart();
        int nacc, lat, cyc;
        run_keys(2'd2, K256, 100, -1, 0, -1, 0, 10, nacc, lat, cyc);
        n_chk++;
        if (cyc !== 61) $display("FAIL aes256_cycles: got %0d want 61", cyc); else n_pass++;
        n_chk++;
        if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) $display("FAIL aes256_round14: got %h want fe4890d1e6188d0b046df344706c631e", got_rk[14]); else n_pass++;
    endtask

    task automatic test_backpressure();
        int nacc, lat, cyc;
        run_keys(2'd0, {K128, rnd128()}, 50, 3, 7, -1, 0, -1, nacc, lat, cyc);
        n_chk++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL bp_round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); else n_pass++;
    endtask

    task automatic test_cfg_err();
        en = 1'b1; start = 1'b1; key_mode = 2'd3; key_i = {rnd128(), rnd128()};
        @(posedge clk); #1;
        start = 1'b0;
        n_chk++;
        if ({cfg_err, busy} !== 2'b10) $display("FAIL cfg_err_pulse: got err=%b busy=%b want 1 0", cfg_err, busy); else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if ({cfg_err, busy} !== 2'b00) $display("FAIL cfg_err_clear: got err=%b busy=%b want 0 0", cfg_err, busy); else n_pass++;
    endtask

    task automatic test_en_freeze();
        int nacc, lat, cyc;
        run_keys(2'd1, {K192, 64'($urandom)}, 100, -1, 0, 20, 5, -1, nacc, lat, cyc);
        n_chk++;
        if (cyc !== 58) $display("FAIL en_shift_cycles: got %0d want 58", cyc); else n_pass++;
        n_chk++;
        if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) $display("FAIL en_round12: got %h want e98ba06f448c773c8ecc720401002202", got_rk[12]); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int nacc, lat, cyc;
        logic found;
        en = 1'b1; rk_if.rk_ready = 1'b1; key_mode = 2'd0; key_i = {K128, 128'h0}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (rk_if.rk_valid && rk_if.rk_idx == 4'd5) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_chk++;
        if (!found) $display("FAIL reach_round5: got no round 5 want round 5 within 100 cycles"); else n_pass++;
        #2 nrst = 1'b0;
        #1;
        n_chk++;
        if ({rk_if.rk_valid, busy, cfg_err, rk_if.rk_idx, rk_if.rk_o, sub_o} !== '0)
            $display("FAIL async_reset: got v=%b busy=%b idx=%0d rk=%h sub=%h want all 0", rk_if.rk_valid, busy, rk_if.rk_idx, rk_if.rk_o, sub_o);
        else
            n_pass++;
        @(posedge clk); @(posedge clk); #1;
        nrst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_chk++;
        if ({rk_if.rk_valid, busy} !== 2'b00) $display("FAIL no_reissue: got v=%b busy=%b want 0 0", rk_if.rk_valid, busy); else n_pass++;
        run_keys(2'd0, {K128, rnd128()}, 100, -1, 0, -1, 0, -1, nacc, lat, cyc);
        n_chk++;
        if (got_rk[0] !== K128) $display("FAIL restart_round0: got %h want %h", got_rk[0], K128); else n_pass++;
    endtask

    task automatic test_random_keys();
        int nacc, lat, cyc;
        for (int t = 0; t < 6; t++)
            run_keys(2'(t % 3), {rnd128(), rnd128()}, 70, -1, 0, -1, 0, -1, nacc, lat, cyc);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256_restart();
        test_backpressure();
        test_cfg_err();
        test_en_freeze();
        test_reset_midrun();
        test_random_keys();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
